// File: rtl/plot_box_seq_pkg.sv
// Shared types, screen limits and the default track layout for the box plotter.
package plot_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  typedef logic [2:0] colour_t;

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, NEXT, DONE} plot_state_t;

  typedef struct packed {
    logic       col_sel;  // 0 = left column, 1 = right column
    logic [6:0] y;
  } box_entry_t;

  // Default 33-box layout, ordered top to bottom across both columns.
  function automatic box_entry_t default_box(input int unsigned idx);
    box_entry_t e;
    e = '0;
    case (idx)
      0:  e = {1'b0, 7'd4};
      1:  e = {1'b1, 7'd7};
      2:  e = {1'b1, 7'd10};
      3:  e = {1'b0, 7'd13};
      4:  e = {1'b1, 7'd16};
      5:  e = {1'b0, 7'd19};
      6:  e = {1'b0, 7'd22};
      7:  e = {1'b0, 7'd25};
      8:  e = {1'b1, 7'd28};
      9:  e = {1'b0, 7'd31};
      10: e = {1'b1, 7'd34};
      11: e = {1'b0, 7'd37};
      12: e = {1'b1, 7'd40};
      13: e = {1'b1, 7'd43};
      14: e = {1'b1, 7'd46};
      15: e = {1'b0, 7'd49};
      16: e = {1'b1, 7'd52};
      17: e = {1'b1, 7'd55};
      18: e = {1'b0, 7'd58};
      19: e = {1'b0, 7'd61};
      20: e = {1'b1, 7'd64};
      21: e = {1'b0, 7'd67};
      22: e = {1'b1, 7'd70};
      23: e = {1'b1, 7'd73};
      24: e = {1'b0, 7'd76};
      25: e = {1'b1, 7'd79};
      26: e = {1'b0, 7'd82};
      27: e = {1'b0, 7'd85};
      28: e = {1'b0, 7'd88};
      29: e = {1'b1, 7'd91};
      30: e = {1'b0, 7'd94};
      31: e = {1'b0, 7'd97};
      32: e = {1'b1, 7'd100};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/plot_box_seq_if.sv
// Pixel write bus between the box plotter (master) and the VGA adapter (slave).
interface plot_if;
  import plot_pkg::*;

  logic [7:0] x;
  logic [6:0] y;
  colour_t    colour;
  logic       plot;
  logic       plot_ready;

  modport master (output x, y, colour, plot, input plot_ready);
  modport slave  (input x, y, colour, plot, output plot_ready);
endinterface

// File: rtl/plot_box_seq_rom.sv
// Synchronous-read box coordinate table holding the default track layout.
module box_coord_rom
  import plot_pkg::*;
#(
  parameter int unsigned NUM_BOXES = 33,
  parameter int unsigned AW        = 6
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] addr,
  output box_entry_t    q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (32'(addr) < NUM_BOXES) begin
      q <= default_box(32'(addr));
    end else begin
      q <= '0;
    end
  end

endmodule

// File: rtl/plot_box_seq.sv
// Multi-lane box rasteriser feeding the VGA write port over a valid/ready bus.
// Optional PLOT_SKIP_MASK_EN adds a per-box enable mask latched at start.
module plot_box_seq
  import plot_pkg::*;
#(
  parameter int unsigned NUM_BOXES       = 33,
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned BOX_W           = 3,
  parameter int unsigned BOX_H           = 3,
  parameter int unsigned X_LEFT          = 38,
  parameter int unsigned X_RIGHT         = 43,
  parameter int unsigned PLAYER_X_STRIDE = 80
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    start,
  input  logic [((NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1)-1:0] player,
  input  colour_t colour_in,
`ifdef PLOT_SKIP_MASK_EN
  input  logic [NUM_BOXES-1:0] box_mask,
`endif
  plot_if.master  pix,
  output logic    busy,
  output logic    done
);

  localparam int unsigned PW  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned IW  = $clog2(NUM_BOXES + 1);
  localparam int unsigned DXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int unsigned DYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  plot_state_t    state;
  logic [PW-1:0]  lane;
  colour_t        col_r;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  rom_addr_c;
  logic [DXW-1:0] dx;
  logic [DXW-1:0] nx_c;
  logic [DYW-1:0] dy;
  logic [DYW-1:0] ny_c;
  box_entry_t     box_q;
  logic [8:0]     px_c;
  logic [8:0]     py_c;
  logic           on_screen_c;
  logic           last_c;
  logic           beat_c;
  logic           idx_last_c;
  logic           draw_box_c;

`ifdef PLOT_SKIP_MASK_EN
  logic [NUM_BOXES-1:0] mask_r;
`endif

  // Look one entry ahead in NEXT so the table word is ready when LOAD starts.
  assign rom_addr_c = (state == NEXT) ? idx + IW'(1) : idx;
  assign idx_last_c = (32'(idx) == NUM_BOXES - 1);
  assign beat_c     = (state == DRAW) && (!pix.plot || pix.plot_ready);

`ifdef PLOT_SKIP_MASK_EN
  assign draw_box_c = mask_r[idx];
`else
  assign draw_box_c = 1'b1;
`endif

  box_coord_rom #(
    .NUM_BOXES (NUM_BOXES),
    .AW        (IW)
  ) u_rom (
    .clk    (clk),
    .resetn (resetn),
    .addr   (rom_addr_c),
    .q      (box_q)
  );

  // Coordinates of the pixel to present next; x steps first, then y.
  always_comb begin
    last_c = (32'(dx) == BOX_W - 1) && (32'(dy) == BOX_H - 1);
    nx_c   = '0;
    ny_c   = '0;
    if (state == DRAW) begin
      if (32'(dx) == BOX_W - 1) begin
        nx_c = '0;
        ny_c = dy + DYW'(1);
      end else begin
        nx_c = dx + DXW'(1);
        ny_c = dy;
      end
    end
    px_c = 9'(box_q.col_sel ? X_RIGHT : X_LEFT)
         + 9'(32'(lane) * PLAYER_X_STRIDE)
         + 9'(nx_c);
    py_c = 9'(box_q.y) + 9'(ny_c);
    on_screen_c = (32'(px_c) < SCREEN_W) && (32'(py_c) < SCREEN_H);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      lane       <= '0;
      col_r      <= '0;
      idx        <= '0;
      dx         <= '0;
      dy         <= '0;
      pix.x      <= '0;
      pix.y      <= '0;
      pix.colour <= '0;
      pix.plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef PLOT_SKIP_MASK_EN
      mask_r     <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            lane  <= (32'(player) < NUM_PLAYERS) ? player : '0;
            col_r <= colour_in;
            idx   <= '0;
            busy  <= 1'b1;
`ifdef PLOT_SKIP_MASK_EN
            mask_r <= box_mask;
`endif
            state <= LOAD;
          end
        end
        LOAD: begin
          if (draw_box_c) begin
            dx         <= '0;
            dy         <= '0;
            pix.x      <= px_c[7:0];
            pix.y      <= py_c[6:0];
            pix.colour <= col_r;
            pix.plot   <= on_screen_c;
            state      <= DRAW;
          end else begin
            state <= NEXT;
          end
        end
        DRAW: begin
          // Off-screen pixels have plot low, so their beat retires at once.
          if (beat_c) begin
            if (last_c) begin
              pix.plot <= 1'b0;
              state    <= NEXT;
            end else begin
              dx       <= nx_c;
              dy       <= ny_c;
              pix.x    <= px_c[7:0];
              pix.y    <= py_c[6:0];
              pix.plot <= on_screen_c;
            end
          end
        end
        NEXT: begin
          idx   <= idx + IW'(1);
          done  <= idx_last_c;
          state <= idx_last_c ? DONE : LOAD;
        end
        DONE: begin
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_box_seq.sv
// Scoreboard bench for plot_box_seq: a layout-level model queues expected pixels,
// a negedge monitor retires them against accepted beats.
module tb_plot_box_seq;

  localparam int NB = 33;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [0:0] player = '0;
  logic [2:0] colour_in = '0;
  logic       busy;
  logic       done;
`ifdef PLOT_SKIP_MASK_EN
  logic [NB-1:0] box_mask = '1;
`endif

  plot_if bus();

  plot_box_seq dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .player    (player),
    .colour_in (colour_in),
`ifdef PLOT_SKIP_MASK_EN
    .box_mask  (box_mask),
`endif
    .pix       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   beats = 0;
  int   done_cnt = 0;
  int   ready_mode = 0;
  int   exp_total = 0;
  int   rise_q[$];
  pix_t exp_q[$];
  pix_t last_acc;
  pix_t last_exp;
  pix_t held;
  bit   hold_pend = 1'b0;
  logic prev_plot = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // plot_ready: 0 = always ready, 1 = random, 2 = repeating 1-0-0-1
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.plot_ready = 1'b1;
      1:       bus.plot_ready = ($urandom_range(0, 3) != 0);
      default: bus.plot_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endcase
  end

  // Monitor: retire accepted beats, verify stalls hold the pixel.
  always @(negedge clk) begin
    pix_t e;
    if (!resetn) begin
      hold_pend = 1'b0;
      prev_plot = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_plot", int'(bus.plot), 1);
        check("hold_x", int'(bus.x), held.x);
        check("hold_y", int'(bus.y), held.y);
        check("hold_colour", int'(bus.colour), held.c);
      end
      hold_pend = 1'b0;
      if (bus.plot && !prev_plot) rise_q.push_back(cyc);
      prev_plot = bus.plot;
      if (bus.plot && bus.plot_ready) begin
        check("pixel_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pix_x", int'(bus.x), e.x);
          check("pix_y", int'(bus.y), e.y);
          check("pix_colour", int'(bus.colour), e.c);
        end
        beats++;
        last_acc = '{int'(bus.x), int'(bus.y), int'(bus.colour)};
      end else if (bus.plot) begin
        hold_pend = 1'b1;
        held = '{int'(bus.x), int'(bus.y), int'(bus.colour)};
      end
      if (done) done_cnt++;
    end
  end

  // Reference: boxes sorted by y over both columns, 3x3 raster, x first.
  task automatic build_expected(input int p, input int c, input logic [NB-1:0] mask);
    int left_y[17]  = '{4, 13, 19, 22, 25, 31, 37, 49, 58, 61, 67, 76, 82, 85, 88, 94, 97};
    int right_y[16] = '{7, 10, 16, 28, 34, 40, 43, 46, 52, 55, 64, 70, 73, 79, 91, 100};
    int bx[$];
    int by[$];
    int lane;
    int px;
    int py;
    exp_q.delete();
    lane = (p < 2) ? p : 0;
    for (int yy = 0; yy < 128; yy++) begin
      foreach (left_y[i])  if (left_y[i] == yy)  begin bx.push_back(38); by.push_back(yy); end
      foreach (right_y[i]) if (right_y[i] == yy) begin bx.push_back(43); by.push_back(yy); end
    end
    for (int b = 0; b < bx.size(); b++) begin
      if (mask[b]) begin
        for (int ddy = 0; ddy < 3; ddy++) begin
          for (int ddx = 0; ddx < 3; ddx++) begin
            px = bx[b] + lane * 80 + ddx;
            py = by[b] + ddy;
            if (px < 160 && py < 120) exp_q.push_back('{px, py, c});
          end
        end
      end
    end
    exp_total = exp_q.size();
    if (exp_total > 0) last_exp = exp_q[exp_total-1];
  endtask

  task automatic issue_start(input int p, input int c, input logic [NB-1:0] mask, output int scyc);
    @(posedge clk);
    #1;
    player    = 1'(p);
    colour_in = 3'(c);
`ifdef PLOT_SKIP_MASK_EN
    box_mask  = mask;
`endif
    start     = 1'b1;
    scyc      = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input int p, input int c, input int mode, input bit repulse,
                     input logic [NB-1:0] mask, input string tag);
    int  n;
    int  scyc;
    int  beats0;
    int  done0;
    int  first;
    bit  seen;
    build_expected(p, c, mask);
    ready_mode = mode;
    beats0 = beats;
    done0  = done_cnt;
    issue_start(p, c, mask, scyc);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20000) begin
      @(negedge clk);
      n++;
      if (n == 5) check({tag, "_busy"}, int'(busy), 1);
      if (done) begin
        seen = 1'b1;
        if (repulse) start = 1'b1;
      end else if (repulse && (n == 40 || n == 300)) begin
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_beats"}, beats - beats0, exp_total);
    check({tag, "_done_count"}, done_cnt - done0, 1);
    check({tag, "_leftover"}, exp_q.size(), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
    if (exp_total > 0) begin
      first = -1;
      foreach (rise_q[i]) if (first < 0 && rise_q[i] > scyc) first = rise_q[i];
      check({tag, "_first_latency"}, first - scyc, 2);
      check({tag, "_last_x"}, last_acc.x, last_exp.x);
      check({tag, "_last_y"}, last_acc.y, last_exp.y);
    end
  endtask

  task automatic reset_mid_draw();
    int n;
    int scyc;
    int done0;
    build_expected(0, 5, '1);
    ready_mode = 1;
    done0 = done_cnt;
    issue_start(0, 5, '1, scyc);
    n = 0;
    while (beats < 93 && n < 20000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("abort_reach_box10", int'(n < 20000), 1);
    resetn = 1'b0;
    #1;
    check("abort_x", int'(bus.x), 0);
    check("abort_y", int'(bus.y), 0);
    check("abort_colour", int'(bus.colour), 0);
    check("abort_plot", int'(bus.plot), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    check("abort_no_done", done_cnt - done0, 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_x", int'(bus.x), 0);
    check("reset_y", int'(bus.y), 0);
    check("reset_colour", int'(bus.colour), 0);
    check("reset_plot", int'(bus.plot), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(negedge clk);
    resetn = 1'b1;

    run(0, 4, 0, 1'b0, '1, "p0");
    run(1, int'($urandom_range(0, 7)), 1, 1'b0, '1, "p1_rand");
    run(0, int'($urandom_range(0, 7)), 2, 1'b0, '1, "ready_1001");
    reset_mid_draw();
    run(1, 2, 1, 1'b0, '1, "after_reset");
    run(0, 6, 0, 1'b1, '1, "repulse");
`ifdef PLOT_SKIP_MASK_EN
    run(0, 4, 0, 1'b0, NB'(1), "mask_bit0");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
